darkbus_xdec: RTL
=================

// Module: darkbus_xdec
// PURPOSE
//  Data-bus decoder between darkriscv X port and its two slaves: on-chip RAM (darkram X port) and IO block.
//  Decodes XADDR, forwards the held request to exactly one slave, returns that slave's XATAO/XDACK to the core.
//  FSM locks the slave choice per transaction, so a late read ack (RAM acks 1 clk after XRD) always returns to the right source.
// PARAMETERS
//  IO_MASK    32'hF000_0000  address bits compared for IO decode
//  IO_BASE    32'h8000_0000  (XADDR & IO_MASK)==IO_BASE -> IO slave, else RAM
//  TIMEOUT    255            max wait clocks before forced completion (XBUS_TIMEOUT_EN only), 1..65535
// PORTS
//  CLK      in   1   clock, all logic on rising edge
//  RES_N    in   1   reset, asynchronous assert, active-low
//  XDREQ    in   1   core request, held high until XDACK
//  XRD      in   1   core read strobe
//  XWR      in   1   core write strobe
//  XBE      in   4   core byte enables
//  XADDR    in   32  core address
//  XATAI    in   32  core write data
//  XATAO    out  32  read data to core
//  XDACK    out  1   ack to core, 1-clk pulse per transaction
//  MDREQ/MRD/MWR  out 1 each  RAM-side request strobes
//  MBE      out  4   RAM byte enables; MADDR out 32; MATAI out 32
//  MATAO    in   32  RAM read data; MDACK in 1 RAM ack
//  PDREQ/PRD/PWR/PBE/PADDR/PATAI  out  IO-side copies (widths as RAM side)
//  PATAO    in   32  IO read data; PDACK in 1 IO ack
//  BUSERR   out  1   sticky timeout flag (0 without XBUS_TIMEOUT_EN)
// BEHAVIOUR
//  Reset (RES_N=0, async): state=IDLE, XDACK=0, XATAO=0, M*/P* strobes=0, BUSERR=0, timer=0.
//  States: IDLE, MBUSY, PBUSY, DONE.
//  IDLE: XDREQ=1 -> decode; strobe the selected slave combinationally in the same clk; go to MBUSY/PBUSY.
//    Write and slave ack in the same clk (RAM write) -> XDACK=1 in that clk, next state DONE.
//  MBUSY/PBUSY: strobes held to the locked slave only, other slave sees DREQ=0.
//    Locked slave DACK=1 -> XDACK=1 in that clk (combinational), XATAO=locked slave data, next state DONE.
//  DONE: one turnaround clk, all strobes 0, XDACK=0; then IDLE. This absorbs the core dropping XDREQ.
//  Result: RAM write = 0 wait clks, RAM read = 1 wait clk, IO = its own DACK latency.
//  XATAO muxed by the locked selection and held until the next transaction completes (registered copy).
//  Address, BE and data pass through unchanged; no width conversion. XRD=XWR=1 is illegal and treated as write.
//  XDREQ dropped while BUSY (protocol violation): strobes drop, FSM -> DONE, no XDACK.
//  Slave DACK seen in IDLE or DONE: ignored, no XDACK.
//  RES_N low mid-transaction: abort immediately, no XDACK; slave strobes drop asynchronously.
// CONFIGURATION
//  `define XBUS_TIMEOUT_EN: timer counts BUSY clks.
//    Reaching TIMEOUT -> XDACK=1, XATAO=32'hDEAD_BEEF, BUSERR<=1 (sticky until reset), state DONE.
//    Timer clears on every entry to BUSY.
//  Without the macro: no timer; BUSY waits indefinitely; BUSERR tied 0.
// STRUCTURE
//  darkbus_pkg.vh: state encodings (S_IDLE..S_DONE), BUS_ERR_DATA=32'hDEAD_BEEF, default IO_BASE/IO_MASK.
//  One sub-module: darkbus_tmo (loadable down-counter, expire pulse), instantiated only under XBUS_TIMEOUT_EN.
// TESTING
//  1 RAM write: XADDR=0x100, XWR=1, XBE=4'hF, MDACK same clk.
//    -> MWR=1, XDACK in that clk, PDREQ never asserted.
//  2 RAM read: XADDR=0x104, MATAO=0x12345678 with MDACK 1 clk later.
//    -> XDACK 1 clk after request, XATAO=0x12345678.
//  3 IO read: XADDR=0x8000_0004, PDACK after 3 clks, PATAO=0xA5.
//    -> XDACK on clk 3, XATAO=0xA5, MDREQ stays 0.
//  4 Back-to-back: RAM read then IO write.
//    -> DONE clk between them, no strobe overlap.
//  5 Reset pulse while in PBUSY.
//    -> all outputs 0 immediately, IDLE after release, late PDACK ignored.
//  6 XBUS_TIMEOUT_EN, TIMEOUT=8, IO never acks.
//    -> XDACK on clk 8, XATAO=0xDEADBEEF, BUSERR=1 and stays 1.

Source files
------------

// File: rtl/darkbus_xdec_pkg.sv
// darkbus_xdec_pkg: state encoding, decode defaults and bus-error data shared by the X-port decoder.
// Related build option: XBUS_TIMEOUT_EN (see darkbus_xdec).
package darkbus_xdec_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MBUSY = 2'd1,
    S_PBUSY = 2'd2,
    S_DONE  = 2'd3
  } xdec_state_e;

  localparam logic [31:0] IO_MASK_DEF  = 32'hF000_0000;
  localparam logic [31:0] IO_BASE_DEF  = 32'h8000_0000;
  localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

  function automatic logic is_io(input logic [31:0] addr,
                                 input logic [31:0] mask,
                                 input logic [31:0] base);
    return ((addr & mask) == base);
  endfunction

endpackage

// File: rtl/darkbus_xdec_tmo.sv
// darkbus_xdec_tmo: loadable down-counter flagging a slave that has not acked within TIMEOUT busy clocks.
// Only present when XBUS_TIMEOUT_EN is defined.
`ifdef XBUS_TIMEOUT_EN
module darkbus_xdec_tmo #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  // Loaded with TIMEOUT-1 so expiry lands on the TIMEOUT-th busy clock.
  localparam logic [15:0] LOAD_VAL = 16'(TIMEOUT - 32'd1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != 16'd0)) begin
      cnt_d = cnt_q - 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == 16'd0);

endmodule
`endif

// File: rtl/darkbus_xdec.sv
// darkbus_xdec: darkriscv X-port decoder steering each transaction to on-chip RAM or the IO block.
// Define XBUS_TIMEOUT_EN to force completion (DEAD_BEEF + sticky BUSERR) on a slave that never acks.
module darkbus_xdec
  import darkbus_xdec_pkg::*;
#(
  parameter logic [31:0] IO_MASK = IO_MASK_DEF,
  parameter logic [31:0] IO_BASE = IO_BASE_DEF,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        res_n_i,
  input  logic        xdreq_i,
  input  logic        xrd_i,
  input  logic        xwr_i,
  input  logic [3:0]  xbe_i,
  input  logic [31:0] xaddr_i,
  input  logic [31:0] xatai_i,
  output logic [31:0] xatao_o,
  output logic        xdack_o,
  output logic        mdreq_o,
  output logic        mrd_o,
  output logic        mwr_o,
  output logic [3:0]  mbe_o,
  output logic [31:0] maddr_o,
  output logic [31:0] matai_o,
  input  logic [31:0] matao_i,
  input  logic        mdack_i,
  output logic        pdreq_o,
  output logic        prd_o,
  output logic        pwr_o,
  output logic [3:0]  pbe_o,
  output logic [31:0] paddr_o,
  output logic [31:0] patai_o,
  input  logic [31:0] patao_i,
  input  logic        pdack_i,
  output logic        buserr_o
);

  xdec_state_e state_q, state_d;
  logic        sel_io_s, act_m_s, act_p_s, xdack_s, tmo_hit_s, expire_s, eff_rd_s;
  logic [31:0] rdata_s, xatao_q;

  assign sel_io_s = is_io(xaddr_i, IO_MASK, IO_BASE);
  // Both strobes high is illegal; write wins.
  assign eff_rd_s = xrd_i & ~xwr_i;

`ifdef XBUS_TIMEOUT_EN
  logic buserr_q;

  darkbus_xdec_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk_i    (clk_i),
    .rst_ni   (res_n_i),
    .load_i   ((state_q == S_IDLE) && xdreq_i),
    .en_i     ((state_q == S_MBUSY) || (state_q == S_PBUSY)),
    .expire_o (expire_s)
  );

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      buserr_q <= 1'b0;
    end else if (tmo_hit_s) begin
      buserr_q <= 1'b1;
    end else begin
      buserr_q <= buserr_q;
    end
  end

  assign buserr_o = buserr_q;
`else
  logic unused_tmo_s;
  assign expire_s     = 1'b0;
  assign buserr_o     = 1'b0;
  assign unused_tmo_s = ^{32'(TIMEOUT), tmo_hit_s};
`endif

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (xdreq_i && xwr_i && (sel_io_s ? pdack_i : mdack_i)) begin
          state_d = S_DONE;
        end else if (xdreq_i) begin
          state_d = sel_io_s ? S_PBUSY : S_MBUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MBUSY: state_d = (!xdreq_i || mdack_i || expire_s) ? S_DONE : S_MBUSY;
      S_PBUSY: state_d = (!xdreq_i || pdack_i || expire_s) ? S_DONE : S_PBUSY;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Only the locked slave is strobed or listened to while busy.
  always_comb begin
    act_m_s   = 1'b0;
    act_p_s   = 1'b0;
    xdack_s   = 1'b0;
    tmo_hit_s = 1'b0;
    rdata_s   = xatao_q;
    case (state_q)
      S_IDLE: begin
        act_m_s = xdreq_i & ~sel_io_s;
        act_p_s = xdreq_i & sel_io_s;
        xdack_s = xdreq_i & xwr_i & (sel_io_s ? pdack_i : mdack_i);
        rdata_s = sel_io_s ? patao_i : matao_i;
      end
      S_MBUSY: begin
        act_m_s   = xdreq_i;
        xdack_s   = xdreq_i & (mdack_i | expire_s);
        tmo_hit_s = xdreq_i & ~mdack_i & expire_s;
        rdata_s   = mdack_i ? matao_i : BUS_ERR_DATA;
      end
      S_PBUSY: begin
        act_p_s   = xdreq_i;
        xdack_s   = xdreq_i & (pdack_i | expire_s);
        tmo_hit_s = xdreq_i & ~pdack_i & expire_s;
        rdata_s   = pdack_i ? patao_i : BUS_ERR_DATA;
      end
      S_DONE: begin
        act_m_s = 1'b0;
        act_p_s = 1'b0;
      end
      default: begin
        act_m_s = 1'b0;
        act_p_s = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      xatao_q <= 32'h0000_0000;
    end else if (xdack_s) begin
      xatao_q <= rdata_s;
    end else begin
      xatao_q <= xatao_q;
    end
  end

  // Reset gating makes strobes and ack drop the moment res_n falls.
  assign xdack_o = xdack_s & res_n_i;
  assign xatao_o = xdack_o ? rdata_s : xatao_q;

  assign mdreq_o = act_m_s & res_n_i;
  assign mrd_o   = mdreq_o & eff_rd_s;
  assign mwr_o   = mdreq_o & xwr_i;
  assign mbe_o   = xbe_i;
  assign maddr_o = xaddr_i;
  assign matai_o = xatai_i;

  assign pdreq_o = act_p_s & res_n_i;
  assign prd_o   = pdreq_o & eff_rd_s;
  assign pwr_o   = pdreq_o & xwr_i;
  assign pbe_o   = xbe_i;
  assign paddr_o = xaddr_i;
  assign patai_o = xatai_i;

endmodule
